alu_issue_seq: RTL
==================

Name: alu_issue_seq

Overview:
- Control-side counterpart of the 64-bit ALU: fetches instruction words, decodes them and drives every ALU input.
- Samples the ALU's result, flag and jump outputs, then commits them to its own 16x64 register file, F1/F2 flag pair and program counter.
- Sits between instruction memory and the ALU. It is the only master of the ALU's instr/operand lines.

Parameters:
XLEN, 64, datapath width (register, ALU operand width)
NREGS, 16, register file depth (4-bit register indices)
PC_W, 16, program counter / imem address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  PC_W  fetch address (= pc), stable while imem_req
imem_valid  in  1  fetch data valid this cycle
imem_data  in  64  instruction word
alu_A  out  XLEN  regs[rs1]
alu_B  out  XLEN  regs[rs2]
alu_reg8  out  XLEN  regs[8] (jump target)
alu_value  out  32  immediate
alu_highlow  out  1  load-half select
alu_F1  out  1  flag F1
alu_F2  out  1  flag F2
alu_instr  out  6  opcode
alu_C  in  XLEN  ALU result
alu_F3  in  1  ALU compare result
alu_addrch  in  1  ALU jump-taken
alu_naddr  in  XLEN  ALU jump target
halted  out  1  sticky halt
illegal  out  1  sticky illegal-opcode indicator
pc_out  out  PC_W  current pc (debug)

Behaviour:
- Instruction word: [5:0] opcode, [9:6] rd, [13:10] rs1, [17:14] rs2, [18] highlow, [31:19] ignored, [63:32] value.
- Reset (synchronous, every state, including mid-fetch):
  - state=FETCH, pc=0, all regs=0, F1=F2=0, IR=0, halted=illegal=0, imem_req=0.
  - All alu_* outputs are 0 while not in EXEC.
- FSM FETCH -> WAIT:
  - FETCH lasts 1 cycle and asserts imem_req with imem_addr=pc.
  - Enter WAIT next cycle.
- WAIT:
  - imem_req stays high; imem_valid is sampled only in WAIT.
  - On imem_valid: IR<=imem_data, go to EXEC. Otherwise stay in WAIT (no timeout).
- EXEC (1 cycle):
  - ALU inputs are driven combinationally from IR and regs; alu_C, alu_F3, alu_addrch, alu_naddr are sampled at the end of the cycle.
  - Commit by opcode:
    - 0-7: regs[rd]<=alu_C. Covers ADD, SUB, SHL, SHR, MOV(4), LOADHALF(5), MOV variants (6, 7).
    - 8-13: no register write; F2<=F1, F1<=alu_F3.
    - 14, 15: no register write, flags unchanged.
    - 63 (HALT): halted<=1, go to HALT, pc unchanged.
    - 16-62: illegal<=1, halted<=1, go to HALT, no commit.
  - PC update for all non-halting opcodes: if alu_addrch, pc<=alu_naddr[PC_W-1:0], else pc<=pc+1 (wraps modulo 2^PC_W).
  - Then return to FETCH.
  - The sequencer honours alu_addrch as given; the ALU gates both jump opcodes with F1, so an unconditional jump with F1=0 falls through.
- HALT: sticky. No requests, no state change until reset.
- Register index 8 is ordinary storage. A write to rd=8 is visible on alu_reg8 from the next instruction.
- Throughput: minimum 3 cycles per instruction (FETCH, WAIT with same-cycle valid, EXEC).

Decomposition:
- Shared package holds:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_MOV=4, OP_LDH=5, OP_MOV6=6, OP_MOV7=7, OP_EQ=8, OP_LT=9, OP_GT=10, OP_NF1=11, OP_AND=12, OP_F1=13, OP_JMP=14, OP_JC=15, OP_HALT=63.
  - Instruction field bit positions.
  - State enum FETCH/WAIT/EXEC/HALT.
- One sub-module: issue_regfile. It has 16x64 storage, two combinational read ports plus a fixed reg8 read, one synchronous write port and synchronous clear on reset.

Test Plan:
- Reset then ADD: preload r1=5, r2=7 via LDH sequences; ADD rd=3 rs1=1 rs2=2 -> r3=12, pc advances by 1, imem_req rises again 1 cycle after EXEC.
- Wait stall: hold imem_valid low 5 cycles in WAIT -> imem_req and imem_addr stable throughout, no register or flag change.
- Compare/flags: r1=3, r2=9, opcode 9 (LT) -> F1=1, F2=previous F1. Then opcode 8 (EQ) -> F1=0, F2=1.
- Jump: r8=0x20, F1=1, opcode 15 -> next imem_addr=0x20. Repeat with F1=0 -> next imem_addr=pc+1.
- Illegal/halt: opcode 0x12 -> illegal=1, halted=1, imem_req stays 0 forever. Opcode 63 -> halted=1, illegal=0.
- Reset mid-WAIT with r5 nonzero -> next cycle state FETCH, pc=0, r5=0, halted=0.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: opcodes, instruction
// field layout, FSM state encoding and opcode classification helpers.
package alu_issue_seq_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_SHL  = 6'd2;
  localparam logic [5:0] OP_SHR  = 6'd3;
  localparam logic [5:0] OP_MOV  = 6'd4;
  localparam logic [5:0] OP_LDH  = 6'd5;
  localparam logic [5:0] OP_MOV6 = 6'd6;
  localparam logic [5:0] OP_MOV7 = 6'd7;
  localparam logic [5:0] OP_EQ   = 6'd8;
  localparam logic [5:0] OP_LT   = 6'd9;
  localparam logic [5:0] OP_GT   = 6'd10;
  localparam logic [5:0] OP_NF1  = 6'd11;
  localparam logic [5:0] OP_AND  = 6'd12;
  localparam logic [5:0] OP_F1   = 6'd13;
  localparam logic [5:0] OP_JMP  = 6'd14;
  localparam logic [5:0] OP_JC   = 6'd15;
  localparam logic [5:0] OP_HALT = 6'd63;

  // Instruction word layout
  localparam int OPC_LSB   = 0;
  localparam int OPC_W     = 6;
  localparam int RD_LSB    = 6;
  localparam int RS1_LSB   = 10;
  localparam int RS2_LSB   = 14;
  localparam int REG_IDX_W = 4;
  localparam int HL_BIT    = 18;
  localparam int VAL_LSB   = 32;
  localparam int VAL_W     = 32;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;

  // Opcodes 0-7 write the ALU result back to rd
  function automatic logic op_writes_reg(input logic [5:0] op);
    return op <= OP_MOV7;
  endfunction

  // Opcodes 8-13 shift the flag pair and capture the compare result
  function automatic logic op_is_cmp(input logic [5:0] op);
    return (op >= OP_EQ) && (op <= OP_F1);
  endfunction

  // Anything above the jumps, other than HALT, is undefined
  function automatic logic op_is_illegal(input logic [5:0] op);
    return (op > OP_JC) && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Bus bundle between the sequencer, instruction memory and the ALU.
// The master side is the sequencer; the slave side is memory plus ALU.
interface alu_issue_seq_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [63:0]     imem_data;
  logic [XLEN-1:0] alu_A;
  logic [XLEN-1:0] alu_B;
  logic [XLEN-1:0] alu_reg8;
  logic [31:0]     alu_value;
  logic            alu_highlow;
  logic            alu_F1;
  logic            alu_F2;
  logic [5:0]      alu_instr;
  logic [XLEN-1:0] alu_C;
  logic            alu_F3;
  logic            alu_addrch;
  logic [XLEN-1:0] alu_naddr;

  modport master (
    output imem_req, imem_addr,
    output alu_A, alu_B, alu_reg8, alu_value, alu_highlow, alu_F1, alu_F2, alu_instr,
    input  imem_valid, imem_data,
    input  alu_C, alu_F3, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr,
    input  alu_A, alu_B, alu_reg8, alu_value, alu_highlow, alu_F1, alu_F2, alu_instr,
    output imem_valid, imem_data,
    output alu_C, alu_F3, alu_addrch, alu_naddr
  );
endinterface

// File: rtl/alu_issue_seq_regfile.sv
// Sequencer register file: two combinational read ports, a fixed read of
// register 8 (the ALU jump target), one synchronous write port.
module issue_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_wa,
  input  logic [XLEN-1:0]          i_wd,
  input  logic [$clog2(NREGS)-1:0] i_ra1,
  input  logic [$clog2(NREGS)-1:0] i_ra2,
  output logic [XLEN-1:0]          o_rd1,
  output logic [XLEN-1:0]          o_rd2,
  output logic [XLEN-1:0]          o_reg8
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Storage: cleared on reset, single write per cycle otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1  = r_regs[i_ra1];
  assign o_rd2  = r_regs[i_ra2];
  assign o_reg8 = r_regs[8];

endmodule

// File: rtl/alu_issue_seq.sv
// ALU issue sequencer: fetches a 64-bit instruction word, drives the ALU
// for exactly one EXEC cycle, then commits result, flags and next pc.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 16,
  parameter int PC_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  alu_issue_seq_if.master  bus,
  output logic             halted,
  output logic             illegal,
  output logic [PC_W-1:0]  pc_out
);

  state_t                 r_state, w_next;
  logic [PC_W-1:0]        r_pc;
  logic [63:0]            r_ir;
  logic                   r_f1, r_f2, r_halted, r_illegal;
  logic                   w_req, w_exec, w_we;
  logic [5:0]             w_op;
  logic [REG_IDX_W-1:0]   w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0]        w_rd1, w_rd2, w_reg8;
  logic                   w_unused_bits;

  assign w_op  = r_ir[OPC_LSB +: OPC_W];
  assign w_rd  = r_ir[RD_LSB  +: REG_IDX_W];
  assign w_rs1 = r_ir[RS1_LSB +: REG_IDX_W];
  assign w_rs2 = r_ir[RS2_LSB +: REG_IDX_W];
  assign w_we  = w_exec && op_writes_reg(w_op);

  // Reserved instruction bits and the jump target above the pc width are ignored
  assign w_unused_bits = ^{r_ir[31:19], bus.alu_naddr[XLEN-1:PC_W]};

  issue_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clock),
    .rst    (reset),
    .i_we   (w_we),
    .i_wa   (w_rd),
    .i_wd   (bus.alu_C),
    .i_ra1  (w_rs1),
    .i_ra2  (w_rs2),
    .o_rd1  (w_rd1),
    .o_rd2  (w_rd2),
    .o_reg8 (w_reg8)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end

  // Next-state and per-state strobes
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_exec = 1'b0;
    case (r_state)
      FETCH: begin
        w_req  = 1'b1;
        w_next = WAIT;
      end
      WAIT: begin
        w_req = 1'b1;
        if (bus.imem_valid) w_next = EXEC;
      end
      EXEC: begin
        w_exec = 1'b1;
        if (op_is_illegal(w_op) || (w_op == OP_HALT)) w_next = HALT;
        else                                          w_next = FETCH;
      end
      default: w_next = HALT;
    endcase
  end

  // Instruction latch and commit of flags, pc and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_f1      <= 1'b0;
      r_f2      <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if ((r_state == WAIT) && bus.imem_valid) r_ir <= bus.imem_data;
      if (w_exec) begin
        if (op_is_illegal(w_op)) begin
          r_illegal <= 1'b1;
          r_halted  <= 1'b1;
        end else if (w_op == OP_HALT) begin
          r_halted <= 1'b1;
        end else begin
          if (op_is_cmp(w_op)) begin
            r_f2 <= r_f1;
            r_f1 <= bus.alu_F3;
          end
          if (bus.alu_addrch) r_pc <= bus.alu_naddr[PC_W-1:0];
          else                r_pc <= r_pc + 1'b1;
        end
      end
    end
  end

  // A request is never presented while reset is held, even in FETCH
  assign bus.imem_req  = w_req & ~reset;
  assign bus.imem_addr = r_pc;

  assign bus.alu_A       = w_exec ? w_rd1  : '0;
  assign bus.alu_B       = w_exec ? w_rd2  : '0;
  assign bus.alu_reg8    = w_exec ? w_reg8 : '0;
  assign bus.alu_value   = w_exec ? r_ir[VAL_LSB +: VAL_W] : '0;
  assign bus.alu_highlow = w_exec & r_ir[HL_BIT];
  assign bus.alu_F1      = w_exec & r_f1;
  assign bus.alu_F2      = w_exec & r_f2;
  assign bus.alu_instr   = w_exec ? w_op : '0;

  assign halted  = r_halted;
  assign illegal = r_illegal;
  assign pc_out  = r_pc;

endmodule
